// File: rtl/drum_pkg.sv
// Shared types for the drum-solver sequencer: node word format and scheduler states.
package drum_pkg;
  localparam int NODE_W = 18;
  localparam int TMR_W  = 8;

  typedef logic signed [NODE_W-1:0] node_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_RD,
    ST_RD_WAIT,
    ST_CALC,
    ST_CALC_WAIT,
    ST_WR,
    ST_STEP_END,
    ST_DONE
  } sched_state_e;
endpackage

// File: rtl/drum_wait_timer.sv
// Down-counting latency timer: load N, then 'expired' is high in the N-th cycle after the load.
module drum_wait_timer
  import drum_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/drum_step_scheduler.sv
// Row/step sequencer for the square-drum column solver: pluck load, per-row read/update/write,
// time-step counting and centre-node sampling.
//
//  state        | meaning
//  IDLE         | waiting for shoot after reset
//  INIT         | writing pluck profile, one row per cycle
//  RD           | read strobe for current row
//  RD_WAIT      | memory read latency
//  CALC         | node-update strobe
//  CALC_WAIT    | node-update latency
//  WR           | write-back of update result, advance row
//  STEP_END     | step complete: count, publish sample, decide restart/stop/continue
//  DONE         | step limit reached, waiting for shoot
module drum_step_scheduler
  import drum_pkg::*;
#(
  parameter int ROWS       = 30,
  parameter int ADDR_W     = 5,
  parameter int RD_LAT     = 2,
  parameter int CALC_LAT   = 3,
  parameter int CENTER_ROW = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shoot,
  input  logic [31:0]              max_iterations,
  input  logic signed [NODE_W-1:0] center_node_in,
  output logic [ADDR_W-1:0]        row_addr,
  output logic                     mem_rd_en,
  output logic                     mem_wr_en,
  output logic                     init_sel,
  output logic                     compute_en,
  output logic                     first_row,
  output logic                     last_row,
  output logic signed [NODE_W-1:0] output_node,
  output logic                     output_ready,
  output logic [31:0]              iterations,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_CTR  = ADDR_W'(CENTER_ROW);

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] row_q;
  logic [31:0]       iter_q;
  logic [31:0]       iter_inc;
  node_t             node_q;
  logic              pend_q;
  logic              at_last;
  logic              limit_hit;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_expired;

  assign at_last   = (row_q == ROW_LAST);
  assign iter_inc  = iter_q + 32'd1;
  assign limit_hit = (max_iterations != 32'd0) && (iter_inc >= max_iterations);

  // One timer serves both waits; RD and CALC are never adjacent to the other's wait.
  assign tmr_load = (state_q == ST_RD) || (state_q == ST_CALC);
  assign tmr_val  = (state_q == ST_RD) ? TMR_W'(RD_LAT) : TMR_W'(CALC_LAT);

  drum_wait_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    init_sel     = 1'b0;
    compute_en   = 1'b0;
    output_ready = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (shoot) state_d = ST_INIT;
      end
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (shoot) state_d = ST_INIT;
      end
      ST_INIT: begin
        mem_wr_en = 1'b1;
        init_sel  = 1'b1;
        if (at_last) state_d = ST_RD;
      end
      ST_RD: begin
        mem_rd_en = 1'b1;
        state_d   = (RD_LAT == 0) ? ST_CALC : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (tmr_expired) state_d = ST_CALC;
      end
      ST_CALC: begin
        compute_en = 1'b1;
        state_d    = (CALC_LAT == 0) ? ST_WR : ST_CALC_WAIT;
      end
      ST_CALC_WAIT: begin
        if (tmr_expired) state_d = ST_WR;
      end
      ST_WR: begin
        mem_wr_en = 1'b1;
        state_d   = at_last ? ST_STEP_END : ST_RD;
      end
      ST_STEP_END: begin
        output_ready = 1'b1;
        if (pend_q || shoot) state_d = ST_INIT;
        else if (limit_hit)  state_d = ST_DONE;
        else                 state_d = ST_RD;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      iter_q  <= '0;
      node_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (shoot) row_q <= '0;
        end
        ST_INIT: begin
          row_q <= at_last ? '0 : row_q + ADDR_W'(1);
          if (at_last) iter_q <= '0;
        end
        ST_WR: begin
          row_q <= at_last ? '0 : row_q + ADDR_W'(1);
          if (row_q == ROW_CTR) node_q <= center_node_in;
        end
        ST_STEP_END: begin
          iter_q <= iter_inc;
          row_q  <= '0;
        end
        default: ;
      endcase
      // A shoot during a step is held until the step boundary so no row is cut short.
      if (state_q == ST_STEP_END)  pend_q <= 1'b0;
      else if (busy && shoot)      pend_q <= 1'b1;
    end
  end

  assign row_addr    = row_q;
  assign iterations  = iter_q;
  assign output_node = node_q;
  assign first_row   = busy && (row_q == '0);
  assign last_row    = busy && at_last;

endmodule
